dataflow_deadlock_monitor: RTL

//  Parametrised N-process deadlock monitor for dataflow co-simulation and debug builds.

---
 rtl/dld_pkg.sv | 38 +++
 rtl/dld_next_hop.sv | 18 +
 rtl/dataflow_deadlock_monitor.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/dld_pkg.sv
// Shared types and helpers for the dataflow deadlock monitor.
// The optional path capture in the top is enabled by the DLD_PATH_CAPTURE_EN macro.
package dld_pkg;

  localparam int IDX_W    = 5;
  localparam int MAX_PROC = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_WALK,
    ST_TRIM,
    ST_CHECK,
    ST_REPORT
  } dld_state_t;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } dld_sel_t;

  function automatic dld_sel_t lowest_set(input logic [MAX_PROC-1:0] vec);
    dld_sel_t sel;
    sel = '0;
    for (int i = MAX_PROC - 1; i >= 0; i--) begin
      if (vec[i]) begin
        sel.vld = 1'b1;
        sel.idx = IDX_W'(i);
      end
    end
    return sel;
  endfunction

  function automatic logic [MAX_PROC-1:0] onehot(input logic [IDX_W-1:0] idx);
    return MAX_PROC'(1) << idx;
  endfunction

endpackage

// File: rtl/dld_next_hop.sv
// Priority encoder over one wait-for row: lowest process the current node waits on.
module dld_next_hop
  import dld_pkg::*;
#(
  parameter int N_PROC = 4
) (
  input  logic [N_PROC-1:0] i_row,
  output logic [IDX_W-1:0]  o_next_idx,
  output logic              o_next_vld
);

  dld_sel_t w_sel;

  assign w_sel      = lowest_set(MAX_PROC'(i_row));
  assign o_next_idx = w_sel.idx;
  assign o_next_vld = w_sel.vld;

endmodule

// File: rtl/dataflow_deadlock_monitor.sv
// Snapshots a settled blocked set, walks the wait-for graph for a cycle and reports it stickily.
// Define DLD_PATH_CAPTURE_EN to also record the cycle visit order on o_dl_path/o_dl_path_len.
module dataflow_deadlock_monitor
  import dld_pkg::*;
#(
  parameter  int N_PROC        = 4,
  parameter  int SETTLE_CYCLES = 16,
  localparam int CNT_W         = $clog2(SETTLE_CYCLES + 1)
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic [N_PROC-1:0]          i_proc_blocked,
  input  logic [N_PROC*N_PROC-1:0]   i_wait_for,
  input  logic                       i_dl_clear,
  output logic                       o_dl_detect,
  output logic [N_PROC-1:0]          o_dl_origin,
  output logic [N_PROC-1:0]          o_dl_members,
  output logic                       o_busy,
  output logic [N_PROC*IDX_W-1:0]    o_dl_path,
  output logic [IDX_W-1:0]           o_dl_path_len
);

  dld_state_t                         r_state;
  logic [CNT_W-1:0]                   r_cnt;
  logic [N_PROC-1:0]                  r_prev_blk, r_snap_blk, r_visited, r_tried, r_members;
  logic [N_PROC-1:0][N_PROC-1:0]      r_snap_wf;
  logic [IDX_W-1:0]                   r_origin, r_cur, r_root;
  logic                               r_detect;
  logic [N_PROC-1:0]                  r_dl_origin, r_dl_members;

  logic [N_PROC-1:0]                  w_row, w_next_oh, w_origin_oh, w_cur_oh;
  logic [N_PROC-1:0][N_PROC-1:0]      w_masked_wf;
  logic [IDX_W-1:0]                   w_next_idx;
  logic                               w_next_vld, w_settled, w_loop_hit;
  dld_sel_t                           w_first, w_cand;

  // Edges to unblocked targets are dropped so the walk only ever follows real waits.
  always_comb begin
    w_masked_wf = '0;
    w_row       = '0;
    for (int i = 0; i < N_PROC; i++) begin
      if (i_proc_blocked[i]) w_masked_wf[i] = i_wait_for[i*N_PROC +: N_PROC] & i_proc_blocked;
      if (r_cur == IDX_W'(i)) w_row = r_snap_wf[i];
    end
  end

  dld_next_hop #(.N_PROC(N_PROC)) u_next_hop (
    .i_row      (w_row),
    .o_next_idx (w_next_idx),
    .o_next_vld (w_next_vld)
  );

  assign w_next_oh   = N_PROC'(onehot(w_next_idx));
  assign w_origin_oh = N_PROC'(onehot(r_origin));
  assign w_cur_oh    = N_PROC'(onehot(r_cur));
  assign w_first     = lowest_set(MAX_PROC'(i_proc_blocked));
  assign w_cand      = lowest_set(MAX_PROC'(r_snap_blk & ~r_tried & ~w_origin_oh));
  assign w_settled   = (r_cnt == CNT_W'(SETTLE_CYCLES - 1));
  assign w_loop_hit  = w_next_vld && |(r_visited & w_next_oh);

  // NOTE: the snapshot and walk registers are plain flops, so they take the async reset
  // like everything else; nothing here is a RAM that would forbid it.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_prev_blk   <= '0;
      r_snap_blk   <= '0;
      r_snap_wf    <= '0;
      r_visited    <= '0;
      r_tried      <= '0;
      r_members    <= '0;
      r_origin     <= '0;
      r_cur        <= '0;
      r_root       <= '0;
      r_detect     <= 1'b0;
      r_dl_origin  <= '0;
      r_dl_members <= '0;
    end else if (i_dl_clear) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_detect     <= 1'b0;
      r_dl_origin  <= '0;
      r_dl_members <= '0;
    end else if (!i_enable && r_state != ST_REPORT) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      // NOTE: every assignment here is non-blocking so all state moves on the same edge.
      case (r_state)
        ST_IDLE: begin
          if (|i_proc_blocked) begin
            r_state    <= ST_SETTLE;
            r_cnt      <= '0;
            r_prev_blk <= i_proc_blocked;
          end
        end
        ST_SETTLE: begin
          if (!(|i_proc_blocked)) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (i_proc_blocked != r_prev_blk) begin
            r_cnt      <= '0;
            r_prev_blk <= i_proc_blocked;
          end else if (w_settled && w_first.vld) begin
            r_state    <= ST_WALK;
            r_cnt      <= '0;
            r_snap_blk <= i_proc_blocked;
            r_snap_wf  <= w_masked_wf;
            r_origin   <= w_first.idx;
            r_cur      <= w_first.idx;
            r_visited  <= N_PROC'(onehot(w_first.idx));
            r_tried    <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_WALK: begin
          if (!w_next_vld) begin
            r_tried <= r_tried | w_origin_oh;
            if (w_cand.vld) begin
              r_origin  <= w_cand.idx;
              r_cur     <= w_cand.idx;
              r_visited <= N_PROC'(onehot(w_cand.idx));
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (w_loop_hit) begin
            r_state   <= ST_TRIM;
            r_root    <= w_next_idx;
            r_cur     <= w_next_idx;
            r_members <= '0;
          end else begin
            r_visited <= r_visited | w_next_oh;
            r_cur     <= w_next_idx;
          end
        end
        ST_TRIM: begin
          r_members <= r_members | w_cur_oh;
          if (w_next_idx == r_root) r_state <= ST_CHECK;
          else                      r_cur   <= w_next_idx;
        end
        ST_CHECK: begin
          // A member that woke up since the snapshot means the cycle is stale.
          if (|(r_members & ~i_proc_blocked)) begin
            r_state    <= ST_SETTLE;
            r_cnt      <= '0;
            r_prev_blk <= i_proc_blocked;
          end else begin
            r_state      <= ST_REPORT;
            r_detect     <= 1'b1;
            r_dl_origin  <= N_PROC'(onehot(r_root));
            r_dl_members <= r_members;
          end
        end
        ST_REPORT: ;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_dl_detect  = r_detect;
  assign o_dl_origin  = r_dl_origin;
  assign o_dl_members = r_dl_members;
  assign o_busy       = (r_state != ST_IDLE) && (r_state != ST_REPORT);

`ifdef DLD_PATH_CAPTURE_EN
  logic [N_PROC*IDX_W-1:0] r_path;
  logic [IDX_W-1:0]        r_path_len;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset || i_dl_clear) begin
      r_path     <= '0;
      r_path_len <= '0;
    end else if (i_enable && r_state == ST_WALK && w_loop_hit) begin
      r_path     <= '0;
      r_path_len <= '0;
    end else if (i_enable && r_state == ST_TRIM) begin
      for (int k = 0; k < N_PROC; k++) begin
        if (r_path_len == IDX_W'(k)) r_path[k*IDX_W +: IDX_W] <= r_cur;
      end
      r_path_len <= r_path_len + IDX_W'(1);
    end
  end

  assign o_dl_path     = r_path;
  assign o_dl_path_len = r_path_len;
`else
  assign o_dl_path     = '0;
  assign o_dl_path_len = '0;
`endif

endmodule
